// File: rtl/eci_reorder_rd_nvc.sv
// eci_reorder_rd_nvc: splits AXI read bursts into single-line (128 B) requests spread over N_VC
// virtual channels by address, and returns the line data in request order through a reorder
// buffer of N_THREADS preallocated slots.
// Optional feature: define ECI_REORDER_RID_CHECK_EN to drop unexpected response ids and flag
// them on the sticky err_rid output.
module eci_reorder_rd_nvc #(
   parameter int unsigned N_VC          = 2,
   parameter int unsigned N_THREADS     = 32,
   parameter int unsigned N_BURSTED     = 2,
   parameter int unsigned ECI_ADDR_BITS = 48,
   parameter int unsigned ECI_DATA_BITS = 1024,
   parameter int unsigned ECI_ID_BITS   = 5
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   // upstream read address
   input  logic [ECI_ADDR_BITS-1:0] axi_in_araddr,
   input  logic [7:0]               axi_in_arlen,
   input  logic                     axi_in_arvalid,
   output logic                     axi_in_arready,
   // upstream read data
   output logic [ECI_DATA_BITS-1:0] axi_in_rdata,
   output logic                     axi_in_rlast,
   output logic [1:0]               axi_in_rresp,
   output logic                     axi_in_rvalid,
   input  logic                     axi_in_rready,
   // per-VC line requests
   output logic [ECI_ADDR_BITS-1:0] axi_out_araddr  [N_VC],
   output logic [ECI_ID_BITS-1:0]   axi_out_arid    [N_VC],
   output logic [7:0]               axi_out_arlen   [N_VC],
   output logic                     axi_out_arvalid [N_VC],
   input  logic                     axi_out_arready [N_VC],
   // per-VC line responses
   input  logic [ECI_DATA_BITS-1:0] axi_out_rdata   [N_VC],
   input  logic [ECI_ID_BITS-1:0]   axi_out_rid     [N_VC],
   input  logic                     axi_out_rvalid  [N_VC],
   output logic                     axi_out_rready  [N_VC],
   output logic                     err_rid
);

   localparam int unsigned IdxW = $clog2(N_THREADS);
   localparam int unsigned VcW  = $clog2(N_VC);
   localparam int unsigned CntW = IdxW + 1;
   localparam logic [ECI_ADDR_BITS-1:0] LineBytes = ECI_ADDR_BITS'(128);
   localparam logic [7:0] MaxLen = 8'(N_BURSTED - 1);

   typedef enum logic [0:0] {StIdle, StSplit} state_e;

   state_e                   state_q, state_d;
   logic [ECI_ADDR_BITS-1:0] addr_q, addr_d;
   logic [7:0]               rem_q, rem_d;     // lines still to issue after the current one
   logic [IdxW-1:0]          head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]          count_q, count_d;
   logic [N_THREADS-1:0]     valid_q, valid_d, last_q, last_d;
   logic [ECI_DATA_BITS-1:0] data_q [N_THREADS];

   logic            full, in_arready, vc_req, ar_hs, vc_hs, drain;
   logic [VcW-1:0]  cur_vc;
   logic [N_VC-1:0] wr_en;
   logic [IdxW-1:0] rid_idx [N_VC];

   assign full   = (count_q == CntW'(N_THREADS));
   assign cur_vc = addr_q[7 +: VcW];
   assign ar_hs  = axi_in_arvalid & in_arready;
   assign vc_hs  = vc_req & axi_out_arready[cur_vc];
   assign drain  = valid_q[head_q] & axi_in_rready;

   // Slot index carried by each VC response.
   always_comb begin
      for (int v = 0; v < N_VC; v++) begin
         rid_idx[v] = axi_out_rid[v][IdxW-1:0];
      end
   end

   // Dispatch FSM state register.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Dispatch FSM next state: leave SPLIT once the final line of the burst is handed off.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (ar_hs) state_d = StSplit;
         StSplit: if (vc_hs && rem_q == 8'd0) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Dispatch FSM outputs: both sides stall while every slot is in use.
   always_comb begin
      in_arready = 1'b0;
      vc_req     = 1'b0;
      unique case (state_q)
         StIdle:  in_arready = !full;
         StSplit: vc_req     = !full;
         default: ;
      endcase
   end

   // Current line address and remaining line count.
   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (ar_hs) begin
         addr_d = axi_in_araddr;
         rem_d  = (axi_in_arlen > MaxLen) ? MaxLen : axi_in_arlen;
      end else if (vc_hs && rem_q != 8'd0) begin
         addr_d = addr_q + LineBytes;
         rem_d  = rem_q - 8'd1;
      end
   end

   // Reorder slot bookkeeping: allocate at tail on VC handshake, drain at head, mark writes.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (drain) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + IdxW'(1);
      end
      if (vc_hs) begin
         last_d[tail_q] = (rem_q == 8'd0);
         tail_d         = tail_q + IdxW'(1);
      end
      case ({vc_hs, drain})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: ;
      endcase
      for (int v = 0; v < N_VC; v++) begin
         if (wr_en[v]) valid_d[rid_idx[v]] = 1'b1;
      end
   end

   // Control state registers.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         addr_q  <= '0;
         rem_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         last_q  <= '0;
      end else begin
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   // Slot data array, written by every accepted VC response; deliberately not reset.
   always_ff @(posedge aclk) begin
      for (int v = 0; v < N_VC; v++) begin
         if (wr_en[v]) data_q[rid_idx[v]] <= axi_out_rdata[v];
      end
   end

`ifdef ECI_REORDER_RID_CHECK_EN
   logic [N_THREADS-1:0] pend_q, pend_d;
   logic                 err_q, err_d;
   logic [N_VC-1:0]      bad;

   // Accept a response only for a pending slot with no same-rid response on another VC.
   always_comb begin
      wr_en = '0;
      bad   = '0;
      for (int v = 0; v < N_VC; v++) begin
         if (axi_out_rvalid[v]) begin
            bad[v] = (32'(axi_out_rid[v]) >= N_THREADS) || !pend_q[rid_idx[v]];
            for (int w = 0; w < N_VC; w++) begin
               if (w != v && axi_out_rvalid[w] && axi_out_rid[w] == axi_out_rid[v]) bad[v] = 1'b1;
            end
            wr_en[v] = !bad[v];
         end
      end
   end

   // Pending set on allocation, cleared on write; error is sticky.
   always_comb begin
      pend_d = pend_q;
      if (vc_hs) pend_d[tail_q] = 1'b1;
      for (int v = 0; v < N_VC; v++) begin
         if (wr_en[v]) pend_d[rid_idx[v]] = 1'b0;
      end
      err_d = err_q | (|bad);
   end

   // Rid check registers.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         err_q  <= err_d;
      end
   end

   assign err_rid = aresetn & err_q;
`else
   // Every response is written into the slot named by its rid.
   always_comb begin
      for (int v = 0; v < N_VC; v++) begin
         wr_en[v] = axi_out_rvalid[v];
      end
   end

   assign err_rid = 1'b0;
`endif

   assign axi_in_arready = aresetn & in_arready;
   assign axi_in_rvalid  = aresetn & valid_q[head_q];
   assign axi_in_rlast   = aresetn & last_q[head_q];
   assign axi_in_rdata   = aresetn ? data_q[head_q] : '0;
   assign axi_in_rresp   = 2'b00;

   // VC request outputs: only the VC owning the current line sees the request.
   always_comb begin
      for (int v = 0; v < N_VC; v++) begin
         logic sel;
         sel                = aresetn && (state_q == StSplit) && (cur_vc == VcW'(v));
         axi_out_arvalid[v] = sel & vc_req;
         axi_out_araddr[v]  = sel ? addr_q : '0;
         axi_out_arid[v]    = sel ? ECI_ID_BITS'(tail_q) : '0;
         axi_out_arlen[v]   = '0;
         axi_out_rready[v]  = 1'b1;
      end
   end

endmodule
